// File: rtl/mul_pkg.sv
// +-----------------------------------------------------------------------+
// | mul_pkg : shared types and constants for the shift-add multiply unit  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  localparam int MUL_ITER = 32;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag_of(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_reg.sv
// +-----------------------------------------------------------------------+
// | multi_reg : loadable right-shift register with a zero guard MSB       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module multi_reg #(
  parameter int WIDTH = 33
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             ShiftR_En,
  input  logic             ShiftR_In,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_q;

  // The MSB is a guard bit kept at zero; shifted-in data lands just below it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_q <= '0;
    end else if (Load) begin
      r_q <= D;
    end else if (ShiftR_En) begin
      r_q <= {1'b0, ShiftR_In, r_q[WIDTH-2:1]};
    end
  end

  assign Q = r_q;

endmodule

`default_nettype wire

// File: rtl/shift_add_mul_ctrl.sv
// +-----------------------------------------------------------------------+
// | shift_add_mul_ctrl : multi-cycle RV32M radix-2 shift-add multiplier   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module shift_add_mul_ctrl
  import mul_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Flush,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [1:0]  Op,
  input  logic [31:0] Rs1,
  input  logic [31:0] Rs2,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_Result
);

  mul_state_t  r_state, w_state_nxt;
  logic [32:0] r_m;
  logic [4:0]  r_cnt;
  logic        r_neg, r_hi;
  logic [31:0] r_result;

  logic        w_s1, w_s2, w_accept, w_fix_latch, w_sub_rst;
  logic        w_a_load, w_q_load, w_q_shift;
  logic [31:0] w_mag1, w_mag2;
  logic [32:0] w_a, w_q, w_a_d, w_sum;
  logic [63:0] w_prod_raw, w_prod;
  logic        w_unused;

  assign w_s1   = (Op != OP_MULHU);
  assign w_s2   = (Op == OP_MULH);
  assign w_mag1 = mag_of(Rs1, w_s1);
  assign w_mag2 = mag_of(Rs2, w_s2);

  assign w_sum      = w_a + (w_q[0] ? r_m : 33'd0);
  assign w_prod_raw = {w_a[31:0], w_q[31:0]};
  assign w_prod     = r_neg ? (~w_prod_raw + 64'd1) : w_prod_raw;
  assign w_sub_rst  = Reset | Flush;
  assign w_unused   = w_q[32];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_a_load    = 1'b0;
    w_a_d       = '0;
    w_q_load    = 1'b0;
    w_q_shift   = 1'b0;
    w_fix_latch = 1'b0;
    case (r_state)
      IDLE: begin
        if (!Flush && In_Valid) begin
          w_accept    = 1'b1;
          w_a_load    = 1'b1;
          w_q_load    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (Flush) begin
          w_state_nxt = IDLE;
        end else begin
          w_a_load  = 1'b1;
          w_a_d     = {1'b0, w_sum[32:1]};
          w_q_shift = 1'b1;
          if (r_cnt == 5'(MUL_ITER - 1)) w_state_nxt = FIX;
        end
      end
      FIX: begin
        if (Flush) begin
          w_state_nxt = IDLE;
        end else begin
          w_fix_latch = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (Flush || Out_Ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_m      <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_hi     <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_m   <= {1'b0, w_mag1};
        r_cnt <= '0;
        r_neg <= (w_s1 & Rs1[31]) ^ (w_s2 & Rs2[31]);
        r_hi  <= (Op != OP_MUL);
      end else if (w_q_shift) begin
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_fix_latch) r_result <= r_hi ? w_prod[63:32] : w_prod[31:0];
    end
  end

  multi_reg #(.WIDTH(33)) u_a_reg (
    .Clk       (Clk),
    .Reset     (w_sub_rst),
    .Load      (w_a_load),
    .D         (w_a_d),
    .ShiftR_En (1'b0),
    .ShiftR_In (1'b0),
    .Q         (w_a)
  );

  multi_reg #(.WIDTH(33)) u_q_reg (
    .Clk       (Clk),
    .Reset     (w_sub_rst),
    .Load      (w_q_load),
    .D         ({1'b0, w_mag2}),
    .ShiftR_En (w_q_shift),
    .ShiftR_In (w_sum[0]),
    .Q         (w_q)
  );

  assign In_Ready   = (r_state == IDLE);
  assign Out_Valid  = (r_state == DONE);
  assign Out_Result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mul_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_shift_add_mul_ctrl : vector table and scoreboard bench for the mul |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_shift_add_mul_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Flush = 1'b0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [1:0]  Op = 2'b00;
  logic [31:0] Rs1 = '0;
  logic [31:0] Rs2 = '0;
  logic        Out_Valid;
  logic        Out_Ready = 1'b0;
  logic [31:0] Out_Result;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  shift_add_mul_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Flush      (Flush),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Op         (Op),
    .Rs1        (Rs1),
    .Rs2        (Rs2),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Out_Result (Out_Result)
  );

  always #5 Clk = ~Clk;

  // Reference uses full 64-bit extended multiplication, not shift-add.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y, p;
    x = (op != 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
    y = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p = x * y;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int guard = 0;
    while (!In_Ready && guard < 100) begin
      tick();
      guard++;
    end
    chk("in_ready_before_issue", {31'b0, In_Ready}, 32'd1);
    In_Valid = 1'b1;
    Op = op;
    Rs1 = a;
    Rs2 = b;
    tick();
    sb.push_back(exp);
    In_Valid = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after the accept edge) at which Out_Valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!Out_Valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume(input int hold);
    logic [31:0] res, exp;
    logic ok;
    res = Out_Result;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (!Out_Valid || In_Ready || Out_Result !== res) ok = 1'b0;
      tick();
    end
    chk("done_hold_stable", {31'b0, ok}, 32'd1);
    Out_Ready = 1'b1;
    tick();
    Out_Ready = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      chk("result", res, exp);
    end
    chk("in_ready_after_handshake", {31'b0, In_Ready}, 32'd1);
    chk("out_valid_after_handshake", {31'b0, Out_Valid}, 32'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold);
    int lat;
    issue(op, a, b, exp);
    wait_valid(lat);
    chk("latency", 32'(lat), 32'd34);
    consume(hold);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_in_ready"}, {31'b0, In_Ready}, 32'd1);
    chk({name, "_out_valid"}, {31'b0, Out_Valid}, 32'd0);
    chk({name, "_out_result"}, Out_Result, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    vecs.push_back('{2'b00, 32'd7,         32'd6,         32'h0000002A, 0});
    vecs.push_back('{2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 0});
    vecs.push_back('{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, 0});
    vecs.push_back('{2'b01, 32'h80000000,  32'h80000000,  32'h40000000, 0});
    vecs.push_back('{2'b10, 32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFF, 0});
    vecs.push_back('{2'b00, 32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFE, 10});
    vecs.push_back('{2'b01, 32'h00000000,  32'hFFFFFFFB,  32'h00000000, 0});
    vecs.push_back('{2'b00, 32'h00000000,  32'hFFFFFFFB,  32'h00000000, 0});
    vecs.push_back('{2'b10, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 0});
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      vecs.push_back('{rop, ra, rb, model(rop, ra, rb), 0});
    end

    repeat (3) tick();
    Reset = 1'b0;
    check_reset_state("reset");

    foreach (vecs[i]) begin
      chk("table_model_agree", model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);
    end

    // Flush wins over a request in IDLE
    In_Valid = 1'b1;
    Flush = 1'b1;
    Op = 2'b00;
    Rs1 = 32'd9;
    Rs2 = 32'd9;
    tick();
    In_Valid = 1'b0;
    Flush = 1'b0;
    chk("idle_flush_not_accepted", {31'b0, In_Ready}, 32'd1);

    // Flush at RUN cycle 15, then MUL 3x5
    issue(2'b00, 32'd100, 32'd200, 32'd20000);
    repeat (14) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    void'(sb.pop_back());
    chk("flush_in_ready", {31'b0, In_Ready}, 32'd1);
    chk("flush_out_valid", {31'b0, Out_Valid}, 32'd0);
    run_op(2'b00, 32'd3, 32'd5, 32'h0000000F, 0);

    // Reset mid-RUN
    issue(2'b11, 32'h12345678, 32'h9ABCDEF0, model(2'b11, 32'h12345678, 32'h9ABCDEF0));
    repeat (10) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    void'(sb.pop_back());
    check_reset_state("reset_mid_run");

    // Reset while in DONE
    issue(2'b00, 32'h00001234, 32'h00000010, 32'h00012340);
    wait_valid(lat);
    chk("latency_pre_reset", 32'(lat), 32'd34);
    chk("done_result_pre_reset", Out_Result, 32'h00012340);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    void'(sb.pop_back());
    check_reset_state("reset_in_done");

    run_op(2'b01, 32'hFFFFFFF9, 32'h00000003, model(2'b01, 32'hFFFFFFF9, 32'h00000003), 0);
    run_op(2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFEB, 0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
